alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencing controller that drives the team's 8-bit combinational ALU: it is the initiator and the ALU is the responder.
- Fetches 16-bit instructions from a synchronous instruction ROM and holds a 4x8 register file.
- Presents operands and opcode to the ALU, then writes back the result and the zero flag.
- Supports immediate loads, unconditional and zero-conditional jumps, and a handshaked output port.

Parameters:
PC_W, 8, program-counter / instruction-address width; jump targets use instr[PC_W-1:0], PC_W <= 8.

Ports:
clk      input   1     clock, all state on rising edge
reset    input   1     asynchronous, active-high reset
imem_addr output PC_W  instruction ROM address (= pc)
imem_data input  16    ROM data, valid one cycle after imem_addr (registered ROM)
alu_a    output  8     ALU operand a
alu_b    output  8     ALU operand b
alu_op   output  3     ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, others yield 0)
alu_res  input   8     ALU result, combinational from alu_a/alu_b/alu_op
alu_z    input   1     ALU zero flag, combinational
dout     output  8     output data
dout_valid output 1    dout holds valid data
dout_ready input 1     sink accepts dout when high with dout_valid
halted   output  1     controller in HALT
start    input   1     restart pulse, honoured only in HALT

Behaviour:
- Reset, asynchronous, wins over everything:
  - pc=0, regs r0..r3=0, zf=0, state=FETCH.
  - dout=0, dout_valid=0, halted=0.
  - alu_a/alu_b/alu_op=0.
- Reset asserted mid-OUT drops dout_valid immediately; the transfer is lost.
- Instruction encoding by instr[15:13]:
  - 000 ALU: op=[12:10], rd=[9:8], rs1=[7:6], rs2=[5:4].
  - 001 LDI: rd=[9:8], imm=[7:0].
  - 010 JZ: target=[PC_W-1:0].
  - 011 JMP: target=[PC_W-1:0].
  - 100 OUT: rs=[9:8].
  - 111 HALT.
  - 101 and 110 are NOP.
- FETCH (1 cycle): imem_addr=pc. Next state is EXEC.
- EXEC (1 cycle): instr=imem_data.
  - ALU:
    - Drive alu_a=r[rs1], alu_b=r[rs2], alu_op=op combinationally.
    - At the clock edge: r[rd]<=alu_res, zf<=alu_z, pc<=pc+1, go to FETCH.
    - rd may equal rs1/rs2; operands are the pre-write values.
  - LDI: r[rd]<=imm, pc+1, go to FETCH; zf unchanged.
  - JZ: pc<=target if zf=1, else pc+1; go to FETCH.
  - JMP: pc<=target, go to FETCH.
  - OUT: dout<=r[rs], dout_valid<=1, go to OUT_WAIT.
  - HALT: halted<=1, go to HALT; pc unchanged.
  - NOP: pc+1, go to FETCH.
- ALU outputs are 0 in every state other than EXEC with an ALU instruction.
- OUT_WAIT:
  - dout and dout_valid are held stable.
  - On a cycle with dout_valid&dout_ready: dout_valid<=0, pc<=pc+1, go to FETCH.
  - dout keeps its last value after the transfer.
  - Each OUT costs a minimum of 3 cycles: EXEC, then OUT_WAIT for at least one cycle, then FETCH.
- HALT: stays indefinitely; start is ignored in every other state. On start=1: pc<=0, halted<=0, go to FETCH; regs and zf are retained.
- pc arithmetic is modulo 2^PC_W: pc=2^PC_W-1 plus 1 wraps to 0.
- Latency:
  - ALU, LDI, JZ, JMP, NOP each take 2 cycles (FETCH+EXEC).
  - OUT takes 2 cycles plus its handshake wait.

Test Plan:
1. ROM: LDI r0,5; LDI r1,3; ALU sub r2,r0,r1; OUT r2; HALT. With dout_ready=1, the bench sees dout=2 with dout_valid high for exactly 1 cycle, then halted=1 and pc=4.
2. LDI r0,7; ALU xor r3,r0,r0; JZ 0x10; at 0x10 OUT r3. Check zf=1 after the xor, pc goes to 0x10, dout=0. Repeat with a ROM that replaces the xor with ALU add r3,r0,r0: JZ not taken, pc=3, r3=14.
3. Backpressure: OUT with dout_ready low for 4 cycles. dout_valid stays high and dout stays stable for 4 cycles; the transfer completes on the first ready cycle; pc increments exactly once.
4. Wrap: JMP 0xFF; at 0xFF NOP. pc goes 0xFF then 0x00; at 0x00 fetch resumes.
5. ALU alias: LDI r1,0xF0; ALU add r1,r1,r1. Expect r1=0xE0 (carry dropped) and zf=0. Also check: ALU op=110 writes 0 and sets zf=1; LDI afterwards leaves zf=1.
6. Reset/start:
   - Assert reset during OUT_WAIT: dout_valid=0 and pc=0 immediately, without waiting for a clock edge.
   - In HALT, start=1: pc=0, halted=0, FETCH next cycle, regs unchanged.
   - start pulsed outside HALT has no effect.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: instruction sequencer that drives an external 8-bit
// combinational ALU. It fetches 16-bit instructions from a registered ROM,
// keeps a 4x8 register file and a zero flag, and owns a valid/ready output port.
//
// Output handshake: dout_valid rises when an OUT instruction executes.
// dout and dout_valid then stay stable until a cycle in which dout_valid and
// dout_ready are both high. The transfer completes on that clock edge, and
// dout_valid falls on the same edge. dout keeps its last value afterwards.
module alu_seq_ctrl #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [2:0]      alu_op,
    input  logic [7:0]      alu_res,
    input  logic            alu_z,
    output logic [7:0]      dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            halted,
    input  logic            start,
    output logic [1:0]      dbg_state,
    output logic            dbg_zf,
    output logic [31:0]     dbg_regs
);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_EXEC     = 2'd1,
        S_OUT_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [2:0] OPC_ALU  = 3'b000;
    localparam logic [2:0] OPC_LDI  = 3'b001;
    localparam logic [2:0] OPC_JZ   = 3'b010;
    localparam logic [2:0] OPC_JMP  = 3'b011;
    localparam logic [2:0] OPC_OUT  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [3:0][7:0]  regs_q, regs_d;
    logic             zf_q, zf_d;
    logic [7:0]       dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             halted_q, halted_d;

    // Instruction fields; the ROM word is valid during EXEC.
    logic [2:0]       opc;
    logic [2:0]       op;
    logic [1:0]       rd;
    logic [1:0]       rs1;
    logic [1:0]       rs2;
    logic [7:0]       imm;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc_inc;

    assign opc    = imem_data[15:13];
    assign op     = imem_data[12:10];
    assign rd     = imem_data[9:8];
    assign rs1    = imem_data[7:6];
    assign rs2    = imem_data[5:4];
    assign imm    = imem_data[7:0];
    assign target = imem_data[PC_W-1:0];
    // Wraps modulo 2^PC_W.
    assign pc_inc = pc_q + PC_W'(1);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                case (opc)
                    OPC_OUT:  state_d = S_OUT_WAIT;
                    OPC_HALT: state_d = S_HALT;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_OUT_WAIT: if (dout_valid_q && dout_ready) state_d = S_FETCH;
            S_HALT:     if (start) state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // ALU drive: operands are live only while an ALU instruction executes.
    always_comb begin
        alu_a  = 8'd0;
        alu_b  = 8'd0;
        alu_op = 3'd0;
        if (state_q == S_EXEC && opc == OPC_ALU) begin
            alu_a  = regs_q[rs1];
            alu_b  = regs_q[rs2];
            alu_op = op;
        end
    end

    // Datapath next values: pc, register file, zero flag, output port, halt.
    always_comb begin
        pc_d         = pc_q;
        regs_d       = regs_q;
        zf_d         = zf_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        halted_d     = halted_q;
        case (state_q)
            S_EXEC: begin
                case (opc)
                    OPC_ALU: begin
                        regs_d[rd] = alu_res;
                        zf_d       = alu_z;
                        pc_d       = pc_inc;
                    end
                    OPC_LDI: begin
                        regs_d[rd] = imm;
                        pc_d       = pc_inc;
                    end
                    OPC_JZ:  pc_d = zf_q ? target : pc_inc;
                    OPC_JMP: pc_d = target;
                    OPC_OUT: begin
                        dout_d       = regs_q[rd];
                        dout_valid_d = 1'b1;
                    end
                    OPC_HALT: halted_d = 1'b1;
                    default:  pc_d = pc_inc;
                endcase
            end
            S_OUT_WAIT: begin
                if (dout_valid_q && dout_ready) begin
                    dout_valid_d = 1'b0;
                    pc_d         = pc_inc;
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything, including an OUT in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= '0;
            regs_q       <= '0;
            zf_q         <= 1'b0;
            dout_q       <= 8'd0;
            dout_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            regs_q       <= regs_d;
            zf_q         <= zf_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign halted     = halted_q;
    assign dbg_state  = state_q;
    assign dbg_zf     = zf_q;
    assign dbg_regs   = regs_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: registered ROM model, reference ALU,
// output monitor, and a linear sequence of checked program runs.
module tb_alu_seq_ctrl;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_OWAIT = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic        clk;
    logic        reset;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_res;
    logic        alu_z;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        halted;
    logic        start;
    logic [1:0]  dbg_state;
    logic        dbg_zf;
    logic [31:0] dbg_regs;

    logic [15:0] rom [256];
    logic [7:0]  obs_q[$];
    int          dv_cycles;
    int          n_vec;
    int          n_err;
    int          cyc;

    alu_seq_ctrl #(.PC_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_res    (alu_res),
        .alu_z      (alu_z),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .halted     (halted),
        .start      (start),
        .dbg_state  (dbg_state),
        .dbg_zf     (dbg_zf),
        .dbg_regs   (dbg_regs)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered instruction ROM.
    always @(posedge clk) imem_data <= rom[imem_addr];

    // Reference ALU.
    always_comb begin
        case (alu_op)
            3'b000:  alu_res = alu_a + alu_b;
            3'b001:  alu_res = alu_a - alu_b;
            3'b010:  alu_res = alu_a & alu_b;
            3'b011:  alu_res = alu_a | alu_b;
            3'b100:  alu_res = alu_a ^ alu_b;
            3'b101:  alu_res = ~alu_a;
            default: alu_res = 8'd0;
        endcase
        alu_z = (alu_res == 8'd0);
    end

    // Output monitor: records accepted transfers and valid cycles.
    initial dv_cycles = 0;
    always @(negedge clk) begin
        if (!reset && dout_valid) begin
            dv_cycles = dv_cycles + 1;
            if (dout_ready) obs_q.push_back(dout);
        end
    end

    function automatic logic [15:0] i_alu(input logic [2:0] op, input logic [1:0] rd,
                                          input logic [1:0] rs1, input logic [1:0] rs2);
        return {3'b000, op, rd, rs1, rs2, 4'b0000};
    endfunction
    function automatic logic [15:0] i_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {3'b001, 3'b000, rd, imm};
    endfunction
    function automatic logic [15:0] i_jz(input logic [7:0] t);
        return {3'b010, 5'b00000, t};
    endfunction
    function automatic logic [15:0] i_jmp(input logic [7:0] t);
        return {3'b011, 5'b00000, t};
    endfunction
    function automatic logic [15:0] i_out(input logic [1:0] rs);
        return {3'b100, 3'b000, rs, 8'h00};
    endfunction
    localparam logic [15:0] I_HALT = 16'hE000;
    localparam logic [15:0] I_NOP  = 16'hA000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    // Hold reset and fill the ROM with HALT before a new program is loaded.
    task automatic begin_test();
        reset = 1'b1;
        start = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) rom[i] = I_HALT;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic wait_halt(input int max_cyc, input string tag);
        int i;
        i = 0;
        while (!halted && i < max_cyc) begin
            tick();
            i = i + 1;
        end
        chk(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic chk_out(input int base, input int exp_n, input logic [7:0] exp_d, input string tag);
        chk({tag, "_cnt"}, obs_q.size() - base, exp_n);
        if (exp_n > 0 && obs_q.size() > base) chk({tag, "_data"}, {24'd0, obs_q[base]}, {24'd0, exp_d});
    endtask

    int obs_base;
    int dv_base;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        start      = 1'b0;
        dout_ready = 1'b1;
        reset      = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = I_HALT;

        // Reset state, checked while reset is held.
        #2 reset = 1'b1;
        #1;
        chk("rst_pc",     {24'd0, imem_addr}, 32'd0);
        chk("rst_state",  {30'd0, dbg_state}, {30'd0, ST_FETCH});
        chk("rst_dout",   {24'd0, dout}, 32'd0);
        chk("rst_dv",     {31'd0, dout_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_alu",    {13'd0, alu_op, alu_a, alu_b}, 32'd0);
        chk("rst_regs",   dbg_regs, 32'd0);
        chk("rst_zf",     {31'd0, dbg_zf}, 32'd0);

        // 1: LDI/LDI/SUB/OUT/HALT with an always-ready sink.
        begin_test();
        rom[0] = i_ldi(2'd0, 8'd5);
        rom[1] = i_ldi(2'd1, 8'd3);
        rom[2] = i_alu(3'b001, 2'd2, 2'd0, 2'd1);
        rom[3] = i_out(2'd2);
        rom[4] = I_HALT;
        dout_ready = 1'b1;
        obs_base = obs_q.size();
        dv_base  = dv_cycles;
        release_reset();
        repeat (4) tick();
        chk("t1_fetch_alu", {13'd0, alu_op, alu_a, alu_b}, 32'd0);
        chk("t1_fetch_pc", {24'd0, imem_addr}, 32'd2);
        tick();
        chk("t1_alu_a", {24'd0, alu_a}, 32'd5);
        chk("t1_alu_b", {24'd0, alu_b}, 32'd3);
        chk("t1_alu_op", {29'd0, alu_op}, 32'd1);
        wait_halt(40, "t1_halt");
        chk("t1_cycles", cyc, 32'd11);
        chk("t1_pc", {24'd0, imem_addr}, 32'd4);
        chk("t1_dout", {24'd0, dout}, 32'd2);
        chk("t1_dv_cycles", dv_cycles - dv_base, 32'd1);
        chk("t1_regs", dbg_regs, 32'h00_02_03_05);
        chk_out(obs_base, 1, 8'd2, "t1_out");

        // 2a: XOR to zero, JZ taken to 0x10, OUT r3.
        begin_test();
        rom[0]     = i_ldi(2'd0, 8'd7);
        rom[1]     = i_alu(3'b100, 2'd3, 2'd0, 2'd0);
        rom[2]     = i_jz(8'h10);
        rom[8'h10] = i_out(2'd3);
        rom[8'h11] = I_HALT;
        obs_base = obs_q.size();
        release_reset();
        repeat (4) tick();
        chk("t2a_zf", {31'd0, dbg_zf}, 32'd1);
        chk("t2a_r3", {24'd0, dbg_regs[31:24]}, 32'd0);
        repeat (2) tick();
        chk("t2a_pc_jump", {24'd0, imem_addr}, 32'h10);
        chk("t2a_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});
        wait_halt(40, "t2a_halt");
        chk("t2a_pc_end", {24'd0, imem_addr}, 32'h11);
        chk_out(obs_base, 1, 8'd0, "t2a_out");

        // 2b: ADD gives non-zero, JZ falls through.
        begin_test();
        rom[0]     = i_ldi(2'd0, 8'd7);
        rom[1]     = i_alu(3'b000, 2'd3, 2'd0, 2'd0);
        rom[2]     = i_jz(8'h10);
        rom[8'h10] = i_out(2'd3);
        obs_base = obs_q.size();
        release_reset();
        repeat (4) tick();
        chk("t2b_zf", {31'd0, dbg_zf}, 32'd0);
        chk("t2b_r3", {24'd0, dbg_regs[31:24]}, 32'd14);
        repeat (2) tick();
        chk("t2b_pc", {24'd0, imem_addr}, 32'd3);
        wait_halt(20, "t2b_halt");
        chk_out(obs_base, 0, 8'd0, "t2b_out");

        // 3: backpressure for 4 cycles on OUT.
        begin_test();
        rom[0] = i_ldi(2'd2, 8'hA5);
        rom[1] = i_out(2'd2);
        rom[2] = I_HALT;
        dout_ready = 1'b0;
        obs_base = obs_q.size();
        release_reset();
        repeat (4) tick();
        chk("t3_dv_first", {31'd0, dout_valid}, 32'd1);
        chk("t3_state", {30'd0, dbg_state}, {30'd0, ST_OWAIT});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_dv_hold", {31'd0, dout_valid}, 32'd1);
            chk("t3_dout_hold", {24'd0, dout}, 32'hA5);
            chk("t3_pc_hold", {24'd0, imem_addr}, 32'd1);
        end
        dout_ready = 1'b1;
        tick();
        chk("t3_dv_drop", {31'd0, dout_valid}, 32'd0);
        chk("t3_pc_inc", {24'd0, imem_addr}, 32'd2);
        chk("t3_dout_keep", {24'd0, dout}, 32'hA5);
        chk("t3_state_fetch", {30'd0, dbg_state}, {30'd0, ST_FETCH});
        wait_halt(20, "t3_halt");
        chk("t3_pc_end", {24'd0, imem_addr}, 32'd2);
        chk_out(obs_base, 1, 8'hA5, "t3_out");

        // 4: pc wrap from 0xFF to 0x00.
        begin_test();
        rom[0]     = i_jmp(8'hFF);
        rom[8'hFF] = I_NOP;
        release_reset();
        repeat (2) tick();
        chk("t4_pc_ff", {24'd0, imem_addr}, 32'hFF);
        repeat (2) tick();
        chk("t4_pc_wrap", {24'd0, imem_addr}, 32'h00);
        chk("t4_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});
        repeat (2) tick();
        chk("t4_refetch", {24'd0, imem_addr}, 32'hFF);

        // 5: aliased operands, carry drop, op 110, LDI keeps zf.
        begin_test();
        rom[0] = i_ldi(2'd1, 8'hF0);
        rom[1] = i_alu(3'b000, 2'd1, 2'd1, 2'd1);
        rom[2] = i_alu(3'b110, 2'd1, 2'd1, 2'd1);
        rom[3] = i_ldi(2'd2, 8'h11);
        rom[4] = I_HALT;
        release_reset();
        repeat (3) tick();
        chk("t5_alu_ops", {13'd0, alu_op, alu_a, alu_b}, {13'd0, 3'b000, 8'hF0, 8'hF0});
        tick();
        chk("t5_r1_add", {24'd0, dbg_regs[15:8]}, 32'hE0);
        chk("t5_zf_add", {31'd0, dbg_zf}, 32'd0);
        repeat (2) tick();
        chk("t5_r1_op6", {24'd0, dbg_regs[15:8]}, 32'h00);
        chk("t5_zf_op6", {31'd0, dbg_zf}, 32'd1);
        repeat (2) tick();
        chk("t5_r2_ldi", {24'd0, dbg_regs[23:16]}, 32'h11);
        chk("t5_zf_ldi", {31'd0, dbg_zf}, 32'd1);
        wait_halt(20, "t5_halt");

        // 6a: asynchronous reset during OUT_WAIT.
        begin_test();
        rom[0] = i_ldi(2'd2, 8'hA5);
        rom[1] = i_out(2'd2);
        dout_ready = 1'b0;
        release_reset();
        repeat (4) tick();
        chk("t6a_dv_before", {31'd0, dout_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6a_dv_async", {31'd0, dout_valid}, 32'd0);
        chk("t6a_pc_async", {24'd0, imem_addr}, 32'd0);
        chk("t6a_dout_async", {24'd0, dout}, 32'd0);
        chk("t6a_state_async", {30'd0, dbg_state}, {30'd0, ST_FETCH});

        // 6b/6c: restart from HALT, start ignored elsewhere.
        begin_test();
        rom[0] = i_ldi(2'd3, 8'h3C);
        rom[1] = i_alu(3'b100, 2'd0, 2'd3, 2'd3);
        rom[2] = I_HALT;
        dout_ready = 1'b1;
        release_reset();
        wait_halt(20, "t6b_halt");
        repeat (3) tick();
        chk("t6b_stay_halt", {29'd0, halted, dbg_state}, {29'd0, 1'b1, ST_HALT});
        chk("t6b_pc_halt", {24'd0, imem_addr}, 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6b_pc_restart", {24'd0, imem_addr}, 32'd0);
        chk("t6b_halted_clr", {31'd0, halted}, 32'd0);
        chk("t6b_state", {30'd0, dbg_state}, {30'd0, ST_FETCH});
        chk("t6b_regs_kept", dbg_regs, 32'h3C_00_00_00);
        chk("t6b_zf_kept", {31'd0, dbg_zf}, 32'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6c_exec_start", {22'd0, halted, dbg_state, imem_addr[6:0]}, {22'd0, 1'b0, ST_FETCH, 7'd1});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6c_fetch_start", {22'd0, halted, dbg_state, imem_addr[6:0]}, {22'd0, 1'b0, ST_EXEC, 7'd1});
        wait_halt(20, "t6c_halt");
        chk("t6c_pc_end", {24'd0, imem_addr}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
